// File: rtl/mlp_host_ctrl.sv
// mlp_host_ctrl: streams input vector and layer weights into the mlp register bus,
// runs the network, waits for DONE/irq with a timeout and returns the signed result.
module mlp_host_ctrl #(
  parameter int N_INPUTS    = 2,
  parameter int N_HIDDEN    = 4,
  parameter int N_OUTPUT    = 1,
  parameter int WORD_WIDTH  = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  mlp_write_en,
  output logic [1:0]            mlp_addr,
  output logic [31:0]           mlp_writedata,
  input  logic [31:0]           mlp_readdata,
  input  logic                  mlp_irq,
  output logic                  busy,
  output logic                  result_valid,
  output logic [OUT_WIDTH-1:0]  result_data,
  output logic                  err
);
  localparam int N_HW  = N_HIDDEN * (N_INPUTS + 1);
  localparam int N_OW  = N_OUTPUT * (N_HIDDEN + 1);
  localparam int N_MAX = (N_HW > N_OW) ? ((N_HW > N_INPUTS) ? N_HW : N_INPUTS) : ((N_OW > N_INPUTS) ? N_OW : N_INPUTS);
  localparam int CW    = $clog2(N_MAX + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {IDLE, LOAD_IN, LOAD_HW, SEL_OUT, LOAD_OW, RUN, POLL, READ, FIN} state_t;

  state_t               r_state;
  logic                 r_ph;
  logic [CW-1:0]        r_cnt;
  logic [TW-1:0]        r_tcnt;
  logic                 r_s_ready, r_we, r_busy, r_result_valid, r_err;
  logic [1:0]           r_addr;
  logic [31:0]          r_wdata;
  logic [OUT_WIDTH-1:0] r_result_data;
  logic [CW-1:0]        w_last;
  logic                 w_done;
  logic [31:0]          w_word;
  state_t               w_next;
  logic                 w_unused;

  assign w_last   = (r_state == LOAD_IN) ? CW'(N_INPUTS - 1) : (r_state == LOAD_HW) ? CW'(N_HW - 1) : CW'(N_OW - 1);
  assign w_done   = (r_cnt == w_last);
  assign w_next   = (r_state == LOAD_IN) ? LOAD_HW : (r_state == LOAD_HW) ? SEL_OUT : RUN;
  assign w_word   = {{(32-WORD_WIDTH){s_data[WORD_WIDTH-1]}}, s_data};
  assign w_unused = ^mlp_readdata;

  assign s_ready       = r_s_ready;
  assign mlp_write_en  = r_we;
  assign mlp_addr      = r_addr;
  assign mlp_writedata = r_wdata;
  assign busy          = r_busy;
  assign result_valid  = r_result_valid;
  assign result_data   = r_result_data;
  assign err           = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ph           <= 1'b0;
      r_cnt          <= '0;
      r_tcnt         <= '0;
      r_s_ready      <= 1'b0;
      r_we           <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_addr         <= 2'd0;
      r_wdata        <= '0;
      r_result_data  <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= LOAD_IN;
          r_busy  <= 1'b1;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_ph    <= 1'b0;
        end
        LOAD_IN, LOAD_HW, LOAD_OW: if (!r_ph) begin
          if (!r_s_ready) r_s_ready <= 1'b1;
          else if (s_valid) begin
            r_s_ready <= 1'b0;
            r_we      <= 1'b1;
            r_wdata   <= w_word;
            r_addr    <= (r_state == LOAD_IN) ? 2'd1 : 2'd2;
            r_ph      <= 1'b1;
          end
        end else begin
          // keep s_ready continuous across the IN->HW boundary so each word costs 2 cycles
          r_we      <= 1'b0;
          r_ph      <= 1'b0;
          r_cnt     <= w_done ? '0 : r_cnt + 1'b1;
          r_s_ready <= !w_done || (r_state == LOAD_IN);
          if (w_done) r_state <= w_next;
        end
        SEL_OUT, RUN: if (!r_ph) begin
          r_we    <= 1'b1;
          r_addr  <= 2'd0;
          r_wdata <= (r_state == SEL_OUT) ? 32'h0000_0008 : 32'h0000_0001;
          r_ph    <= 1'b1;
        end else begin
          r_we      <= 1'b0;
          r_ph      <= 1'b0;
          r_s_ready <= (r_state == SEL_OUT);
          r_tcnt    <= '0;
          r_state   <= (r_state == SEL_OUT) ? LOAD_OW : POLL;
        end
        POLL: begin
          r_tcnt <= r_tcnt + 1'b1;
          // readdata in the first poll cycle still belongs to the previous address
          if (mlp_irq || (r_tcnt != '0 && mlp_readdata[1])) begin
            r_state <= READ;
            r_addr  <= 2'd3;
            r_ph    <= 1'b0;
          end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        READ: if (!r_ph) r_ph <= 1'b1;
        else begin
          r_ph           <= 1'b0;
          r_result_data  <= mlp_readdata[OUT_WIDTH-1:0];
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_addr         <= 2'd0;
          r_state        <= FIN;
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_host_ctrl.sv
// tb_mlp_host_ctrl: table-driven check of the mlp host sequencer against a bus-slave stub.
module tb_mlp_host_ctrl;
  logic        clk = 0, rst = 1, start = 0, s_valid = 0, s_ready;
  logic [15:0] s_data = '0;
  logic        mlp_write_en, mlp_irq, busy, result_valid, err;
  logic [1:0]  mlp_addr;
  logic [31:0] mlp_writedata, mlp_readdata;
  logic [15:0] result_data;

  mlp_host_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mlp_write_en(mlp_write_en), .mlp_addr(mlp_addr), .mlp_writedata(mlp_writedata),
    .mlp_readdata(mlp_readdata), .mlp_irq(mlp_irq), .busy(busy), .result_valid(result_valid),
    .result_data(result_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic ctrl; logic [15:0] word; logic [1:0] addr; logic [31:0] exp; } vec_t;
  typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;
  vec_t        vec[21];
  logic [15:0] words[19];
  wr_t         wq[$];
  int tests = 0, fails = 0, cyc = 0;
  int gap_err, orphan, hs_cnt, fifo_wr, rv_cnt, rv_cyc, irq_cyc, err_cyc, run_cyc, first_rdy, last_wr_cyc;
  logic prev_we = 0, never_done = 0;

  // mlp bus-slave stub: DONE 8 cycles after a run write, OUTPUT register low half = 4
  logic mlp_done; int dcnt;
  always @(posedge clk or posedge rst)
    if (rst) begin mlp_readdata <= '0; mlp_done <= 0; mlp_irq <= 0; dcnt <= 0; end
    else begin
      mlp_irq <= 0;
      mlp_readdata <= (mlp_addr == 2'd3) ? 32'hABCD_0004 : (mlp_addr == 2'd0) ? {30'd0, mlp_done, 1'b0} : 32'd0;
      if (mlp_write_en && mlp_addr == 2'd0 && mlp_writedata[0]) begin mlp_done <= 0; dcnt <= 8; end
      else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1 && !never_done) begin mlp_done <= 1; mlp_irq <= 1; end
      end
    end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mlp_write_en) begin
      wq.push_back('{mlp_addr, mlp_writedata});
      last_wr_cyc = cyc;
      if (prev_we) gap_err++;
      if (mlp_addr != 2'd0) begin
        if (fifo_wr >= hs_cnt) orphan++;
        fifo_wr++;
      end
      if (mlp_addr == 2'd0 && mlp_writedata == 32'h1) run_cyc = cyc;
    end
    prev_we = mlp_write_en;
    if (s_valid && s_ready) hs_cnt++;
    if (s_ready && first_rdy < 0) first_rdy = cyc;
    if (mlp_irq && irq_cyc < 0) irq_cyc = cyc;
    if (result_valid) begin rv_cnt++; rv_cyc = cyc; end
    if (err && err_cyc < 0) err_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    gap_err = 0; orphan = 0; hs_cnt = 0; fifo_wr = 0; rv_cnt = 0;
    rv_cyc = -1; irq_cyc = -1; err_cyc = -1; run_cyc = -1; first_rdy = -1; last_wr_cyc = -1;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_s_ready"}, s_ready, 0);
    chk({t, "_write_en"}, mlp_write_en, 0);
    chk({t, "_addr"}, mlp_addr, 0);
    chk({t, "_writedata"}, mlp_writedata, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_result_valid"}, result_valid, 0);
    chk({t, "_result_data"}, result_data, 0);
    chk({t, "_err"}, err, 0);
  endtask

  task automatic feed(input int n, input bit stall);
    int k = 0, budget = 0;
    logic hs;
    while (k < n && budget < 3000) begin
      @(negedge clk);
      if (stall && $urandom_range(0, 1) == 0) s_valid = 0;
      else begin s_valid = 1; s_data = words[k]; end
      hs = s_valid && s_ready;
      @(posedge clk);
      if (hs) k++;
      budget++;
    end
    #1 s_valid = 0;
    chk("feed_words", k, n);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    clear_mon();
    @(negedge clk) start = 0;
  endtask

  task automatic do_run(input string t, input bit stall, input bit extra);
    int w = 0;
    pulse_start();
    chk({t, "_busy_rise"}, busy, 1);
    chk({t, "_ready_late"}, s_ready, 0);
    chk({t, "_err_clr"}, err, 0);
    fork
      feed(19, stall);
      begin
        @(negedge clk) chk({t, "_ready_rise"}, s_ready, 1);
        if (extra) begin
          repeat (12) @(negedge clk);
          start = 1;
          @(negedge clk) start = 0;
        end
      end
    join
    while (rv_cnt == 0 && w < 1000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk({t, "_rv_count"}, rv_cnt, 1);
    chk({t, "_result"}, result_data, 16'd4);
    chk({t, "_busy_end"}, busy, 0);
    chk({t, "_err_end"}, err, 0);
    chk({t, "_nwrites"}, wq.size(), 21);
    for (int j = 0; j < 21 && j < wq.size(); j++) begin
      chk($sformatf("%s_wr%0d_addr", t, j), wq[j].a, vec[j].addr);
      chk($sformatf("%s_wr%0d_data", t, j), wq[j].d, vec[j].exp);
    end
    chk({t, "_gaps"}, gap_err, 0);
    chk({t, "_orphan_wr"}, orphan, 0);
    chk({t, "_done_lat"}, rv_cyc - irq_cyc, 3);
    if (!stall) chk({t, "_load_cycles"}, last_wr_cyc - first_rdy + 1, 42);
  endtask

  initial begin
    int w;
    for (int j = 0; j < 21; j++) vec[j] = '{1'b0, 16'h0000, 2'd2, 32'h0000_0000};
    vec[0] = '{1'b0, 16'h0007, 2'd1, 32'h0000_0007};
    vec[1] = '{1'b0, 16'hFFFD, 2'd1, 32'hFFFF_FFFD};
    for (int n = 0; n < 4; n++) vec[2 + 3*n] = '{1'b0, 16'h0100, 2'd2, 32'h0000_0100};
    vec[14] = '{1'b1, 16'h0000, 2'd0, 32'h0000_0008};
    for (int j = 16; j < 20; j++) vec[j] = '{1'b0, 16'h0100, 2'd2, 32'h0000_0100};
    vec[20] = '{1'b1, 16'h0000, 2'd0, 32'h0000_0001};
    w = 0;
    for (int j = 0; j < 21; j++) if (!vec[j].ctrl) begin words[w] = vec[j].word; w++; end
    clear_mon();

    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 0;

    do_run("nominal", 0, 0);
    do_run("start_busy", 0, 1);
    do_run("stall", 1, 1);

    never_done = 1;
    pulse_start();
    feed(19, 0);
    w = 0;
    while (err_cyc < 0 && w < 400) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_no_result", rv_cnt, 0);
    chk("to_latency_ok", (err_cyc - run_cyc >= 64) && (err_cyc - run_cyc <= 66), 1);
    never_done = 0;
    do_run("after_to", 0, 0);

    pulse_start();
    feed(5, 0);
    #1 rst = 1;
    #1 check_reset("midrst");
    @(negedge clk) rst = 0;
    do_run("after_rst", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mlp_host_ctrl.md
# mlp_host_ctrl

Hardware host sequencer for the `mlp` accelerator's register bus. It consumes one 16-bit word stream carrying the input vector, then the hidden-layer weights, then the output-layer weights. It loads these into the `mlp` FIFOs, selects the layer, starts the run, waits for DONE/irq and returns the signed result. It replaces the software host in FPGA builds and sits between a DMA/ROM word source and `mlp`.

## Interface
- N_INPUTS, 2: input vector length.
- N_HIDDEN, 4: hidden neurons.
- N_OUTPUT, 1: output neurons (result read once; only N_OUTPUT=1 supported).
- WORD_WIDTH, 16: stream word width (IN_WIDTH = WGT_WIDTH).
- OUT_WIDTH, 16: result width.
- TIMEOUT_CYC, 4096: maximum cycles spent waiting for DONE.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; ignored while busy.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid&&s_ready.
- s_data  in  WORD_WIDTH  signed word (bias first per neuron, then weights in input order).
- mlp_write_en  out  1  bus write strobe.
- mlp_addr  out  2  0=CTRL, 1=INPUT_FIFO, 2=WEIGHT_FIFO, 3=OUTPUT.
- mlp_writedata  out  32  bus write data.
- mlp_readdata  in  32  registered read data (valid 1 cycle after mlp_addr).
- mlp_irq  in  1  completion interrupt.
- busy  out  1  high from start accept until result_valid/err.
- result_valid  out  1  one-cycle pulse.
- result_data  out  OUT_WIDTH  signed result, held until next start.
- err  out  1  timeout flag; sticky until next accepted start.

## Operation
- States: IDLE, LOAD_IN, LOAD_HW, SEL_OUT, LOAD_OW, RUN, POLL, READ, FIN.
- IDLE: start -> LOAD_IN, busy=1, err cleared, word counter=0.
- Load states use two phases. ACCEPT: s_ready=1; on s_valid, register the sign-extended word into mlp_writedata. WRITE: mlp_write_en=1 with addr 1 in LOAD_IN and addr 2 in LOAD_HW/LOAD_OW; s_ready=0. Then return to ACCEPT or advance.
- Word counts:
  - LOAD_IN takes N_INPUTS words.
  - LOAD_HW takes N_HIDDEN*(N_INPUTS+1) words (12 at defaults).
  - LOAD_OW takes N_OUTPUT*(N_HIDDEN+1) words (5 at defaults).
- SEL_OUT: a single CTRL write of 0x0000_0008 (layer-select bit 3).
- RUN: a single CTRL write of 0x0000_0001 (run bit 0).
- Every bus write is exactly one cycle, followed by at least one cycle with mlp_write_en=0.
- POLL: mlp_addr=0, write_en=0, timeout counter runs. Exit to READ when mlp_irq=1 or mlp_readdata[1]=1. readdata is ignored on the first POLL cycle (stale address).
- Timeout: when the counter reaches TIMEOUT_CYC, set err=1, busy=0 and go to IDLE. result_valid is not asserted.
- READ: mlp_addr=3 for 2 cycles. On the 2nd cycle, capture mlp_readdata[OUT_WIDTH-1:0] into result_data.
- FIN: result_valid=1 for one cycle, busy=0, go to IDLE.
- Arithmetic: mlp_writedata = {{(32-WORD_WIDTH){s_data[msb]}}, s_data}. No other arithmetic.
- Stream stall (s_valid low): remain in ACCEPT indefinitely. There is no timeout during load.
- start in a non-IDLE state: ignored, with no side effects.

## Timing
- Reset values: s_ready=0, mlp_write_en=0, mlp_addr=0, mlp_writedata=0, busy=0, result_valid=0, result_data=0, err=0; state IDLE.
- Reset mid-operation: everything returns to IDLE immediately. The partially loaded `mlp` is reset by the same rst.
- All outputs are registered.
- busy rises 1 cycle after start is sampled.
- s_ready rises in the cycle after that.
- With s_valid held high, each data word costs 2 cycles.
- 19 words plus 2 CTRL writes take 42 cycles at defaults.
- Result latency from DONE observed: result_valid 3 cycles later (READ 2 cycles + FIN).

## Test plan
- Nominal run: inputs [7,-3]; every hidden neuron has bias 256, weights 0; output bias 0, all weights 256, against the behavioral `mlp` -> result_data=4. The INPUT_FIFO writes are 0x00000007 then 0xFFFFFFFD. Exactly 19 FIFO writes and 2 CTRL writes occur, with a write_en gap after each.
- Write ordering: a CTRL write of 0x8 appears after the 12th WEIGHT_FIFO write and before the 13th. The CTRL write of 0x1 follows the 17th.
- Stream stalls: s_valid toggled randomly (~50%) -> bus write sequence identical to the nominal run and result 4. There is never a write without an accepted word.
- Timeout: a stub that never asserts DONE/irq, with TIMEOUT_CYC=64 -> err=1 and busy=0 ~64 cycles after entering POLL, no result_valid. A new start clears err.
- Reset mid-load: assert rst after the 5th word -> all outputs return to their reset values asynchronously. A fresh start then completes normally with result 4.
- A start pulse while busy has no effect: write count and result are unchanged.
